// File: rtl/decode_stage.sv
// decode_stage: registered RV32I/RV64I decoder with valid/ready handshakes, 2-entry skid storage, flush and saturating illegal counter
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_insn,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       out_opcode,
  output logic [3:0]       out_alu_op,
  output logic [2:0]       out_bcu_op,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic             out_rd_we,
  output logic             out_rs1_used,
  output logic             out_rs2_used,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);
  localparam logic [4:0] OP_LOAD = 5'b00000, OP_MISC = 5'b00011, OP_IMM = 5'b00100,
    OP_AUIPC = 5'b00101, OP_IMM32 = 5'b00110, OP_STORE = 5'b01000, OP_OP = 5'b01100,
    OP_LUI = 5'b01101, OP_OP32 = 5'b01110, OP_BRANCH = 5'b11000, OP_JALR = 5'b11001,
    OP_JAL = 5'b11011, OP_SYSTEM = 5'b11100;
  localparam bit RV64 = (XLEN == 64);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      opcode;
    logic [3:0]      alu_op;
    logic [2:0]      bcu_op;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            rd_we;
    logic            rs1_used;
    logic            rs2_used;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } bundle_t;

  bundle_t dec, o_b, s_b;
  logic o_valid, s_valid, accept, o_load;
  logic [4:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  logic is_load, is_misc, is_opimm, is_auipc, is_opimm32, is_store, is_op, is_lui;
  logic is_op32, is_br, is_jalr, is_jal, is_sys, shift_imm, op_ok;
  logic load_bad, store_bad, op_bad, sh_bad, ill;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm32;

  assign op = in_insn[6:2];
  assign f3 = in_insn[14:12];
  assign f7 = in_insn[31:25];
  assign is_load    = op == OP_LOAD;
  assign is_misc    = op == OP_MISC;
  assign is_opimm   = op == OP_IMM;
  assign is_auipc   = op == OP_AUIPC;
  assign is_opimm32 = op == OP_IMM32;
  assign is_store   = op == OP_STORE;
  assign is_op      = op == OP_OP;
  assign is_lui     = op == OP_LUI;
  assign is_op32    = op == OP_OP32;
  assign is_br      = op == OP_BRANCH;
  assign is_jalr    = op == OP_JALR;
  assign is_jal     = op == OP_JAL;
  assign is_sys     = op == OP_SYSTEM;
  assign shift_imm  = (is_opimm | is_opimm32) & (f3 == 3'b001 | f3 == 3'b101);

  assign imm_i = {{20{in_insn[31]}}, in_insn[31:20]};
  assign imm_s = {{20{in_insn[31]}}, in_insn[31:25], in_insn[11:7]};
  assign imm_b = {{20{in_insn[31]}}, in_insn[7], in_insn[30:25], in_insn[11:8], 1'b0};
  assign imm_u = {in_insn[31:12], 12'b0};
  assign imm_j = {{12{in_insn[31]}}, in_insn[19:12], in_insn[20], in_insn[30:21], 1'b0};
  assign imm32 = (is_lui | is_auipc) ? imm_u :
                 is_jal ? imm_j :
                 (is_jalr | is_load | is_opimm | is_opimm32 | is_misc | is_sys) ? imm_i :
                 is_store ? imm_s :
                 is_br ? imm_b : 32'b0;

  assign op_ok = is_load | is_misc | is_opimm | is_auipc | is_store | is_op | is_lui |
                 is_br | is_jalr | is_jal | is_sys | (RV64 & (is_opimm32 | is_op32));
  assign load_bad  = is_load & (f3 == 3'b111 | (!RV64 & (f3 == 3'b011 | f3 == 3'b110)));
  assign store_bad = is_store & (f3[2] | (!RV64 & f3 == 3'b011));
  assign op_bad = (is_op | is_op32) & (!(f7 == 7'h00 | f7 == 7'h20) |
                  (f7 == 7'h20 & !(f3 == 3'b000 | f3 == 3'b101)) |
                  (is_op32 & !(f3 == 3'b000 | f3 == 3'b001 | f3 == 3'b101)));
  // RV64 OP-IMM shifts use a 6-bit shamt, so only insn[31:26] is the funct field there
  assign sh_bad = shift_imm & ((RV64 & is_opimm) ?
                  !(in_insn[31:26] == 6'h00 | (in_insn[31:26] == 6'h10 & f3 == 3'b101)) :
                  !(f7 == 7'h00 | (f7 == 7'h20 & f3 == 3'b101)));
  assign ill = in_insn[1:0] != 2'b11 | in_insn == 32'h0 | &in_insn | !op_ok |
               (is_jalr & f3 != 3'b000) | (is_br & f3[2:1] == 2'b01) |
               load_bad | store_bad | op_bad | sh_bad;

  // combinational decode of the offered instruction
  always_comb begin
    dec.pc       = in_pc;
    dec.opcode   = op;
    dec.alu_op   = {(is_op | is_op32 | shift_imm) & in_insn[30], f3};
    dec.bcu_op   = f3;
    dec.rd       = in_insn[11:7];
    dec.rs1      = in_insn[19:15];
    dec.rs2      = in_insn[24:20];
    dec.rd_we    = !ill & (in_insn[11:7] != 5'd0) & (is_lui | is_auipc | is_jal | is_jalr |
                   is_load | is_op | is_op32 | is_opimm | is_opimm32);
    dec.rs1_used = !ill & !(is_lui | is_auipc | is_jal | is_misc);
    dec.rs2_used = !ill & (is_br | is_store | is_op | is_op32);
    dec.imm      = XLEN'($signed(imm32));
    dec.illegal  = ill;
  end

  assign in_ready = !s_valid;
  assign accept   = in_valid & !s_valid;
  assign o_load   = !o_valid | out_ready;

  // output register refills from skid first to keep order; skid catches accepts while output stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid <= 1'b0;
      s_valid <= 1'b0;
      o_b     <= '0;
      s_b     <= '0;
    end else if (flush) begin
      o_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (o_load) begin
      o_valid <= s_valid | accept;
      s_valid <= 1'b0;
      if (s_valid | accept) o_b <= s_valid ? s_b : dec;
    end else if (accept) begin
      s_valid <= 1'b1;
      s_b     <= dec;
    end
  end

  // saturating count of illegal bundles handed to execute
  always_ff @(posedge clk or posedge rst) begin
    if (rst) illegal_cnt <= '0;
    else if (o_valid & out_ready & o_b.illegal & !(&illegal_cnt)) illegal_cnt <= illegal_cnt + 1'b1;
  end

  assign out_valid    = o_valid;
  assign out_pc       = o_b.pc;
  assign out_opcode   = o_b.opcode;
  assign out_alu_op   = o_b.alu_op;
  assign out_bcu_op   = o_b.bcu_op;
  assign out_rd       = o_b.rd;
  assign out_rs1      = o_b.rs1;
  assign out_rs2      = o_b.rs2;
  assign out_rd_we    = o_b.rd_we;
  assign out_rs1_used = o_b.rs1_used;
  assign out_rs2_used = o_b.rs2_used;
  assign out_imm      = o_b.imm;
  assign out_illegal  = o_b.illegal;
endmodule
